// File: rtl/sync_fifo_flags.sv
// Single-clock show-ahead FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_PARITY_EN to store a per-entry even-parity bit and add par_inj / par_err.
module sync_fifo_flags #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int PNTR_W    = 3,
  parameter int CNT_W     = 4,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              FIFO_clr_n,
  input  logic              FIFO_reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_clr,
`ifdef FIFO_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

`ifdef FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [PNTR_W-1:0] top_q, top_d, btm_q, btm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_en, rd_en, ovf_set, udf_set;
  logic [MEM_W-1:0]  wr_word;

  assign full         = (cnt_q == CNT_W'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CNT_W'(AFULL_TH));
  assign almost_empty = (cnt_q <= CNT_W'(AEMPTY_TH));
  assign cnt          = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign data_out     = empty ? '0 : mem_q[btm_q][DATA_W-1:0];

  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign wr_en   = FIFO_reset_n & push & (~full | pop);
  assign rd_en   = FIFO_reset_n & pop & ~empty;
  assign ovf_set = FIFO_reset_n & push & ~pop & full;
  assign udf_set = FIFO_reset_n & pop & empty;

`ifdef FIFO_PARITY_EN
  assign wr_word = {(^data_in) ^ par_inj, data_in};
`else
  assign wr_word = data_in;
`endif

  always_comb begin
    top_d = top_q;
    btm_d = btm_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (!FIFO_reset_n) begin
      top_d = '0;
      btm_d = '0;
      cnt_d = '0;
    end else begin
      if (err_clr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
      if (wr_en) top_d = top_q + PNTR_W'(1);
      if (rd_en) btm_d = btm_q + PNTR_W'(1);
      if (wr_en && !rd_en)      cnt_d = cnt_q + CNT_W'(1);
      else if (rd_en && !wr_en) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge FIFO_clr_n) begin
    if (!FIFO_clr_n) begin
      top_q <= '0;
      btm_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      top_q <= top_d;
      btm_q <= btm_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (wr_en) mem_q[top_q] <= wr_word;
    end
  end

`ifdef FIFO_PARITY_EN
  logic par_err_q, par_err_d, par_bad;

  assign par_bad = mem_q[btm_q][DATA_W] != (^mem_q[btm_q][DATA_W-1:0]);
  assign par_err = par_err_q;

  always_comb begin
    par_err_d = par_err_q;
    if (FIFO_reset_n) begin
      if (err_clr) par_err_d = 1'b0;
      if (rd_en && par_bad) par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge FIFO_clr_n) begin
    if (!FIFO_clr_n) par_err_q <= 1'b0;
    else             par_err_q <= par_err_d;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_sync_fifo_flags;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          FIFO_clr_n, FIFO_reset_n, push, pop, err_clr;
  logic [DW-1:0] data_in, data_out;
  logic [3:0]    cnt;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef FIFO_PARITY_EN
  logic          par_inj, par_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_udf;

  typedef struct {
    logic          p, po, ec, rn;
    logic [DW-1:0] din;
    int            exp_cnt;
    logic [DW-1:0] exp_dout;
    logic          exp_ovf, exp_udf;
  } vec_t;
  vec_t vtab[$];

  sync_fifo_flags dut (
    .clk(clk), .FIFO_clr_n(FIFO_clr_n), .FIFO_reset_n(FIFO_reset_n),
    .push(push), .pop(pop), .data_in(data_in), .err_clr(err_clr),
`ifdef FIFO_PARITY_EN
    .par_inj(par_inj), .par_err(par_err),
`endif
    .data_out(data_out), .cnt(cnt), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic p, po, ec, rn, input logic [DW-1:0] din,
                              input int c, input logic [DW-1:0] dout, input logic ov, ud);
    vec_t v;
    v.p = p; v.po = po; v.ec = ec; v.rn = rn; v.din = din;
    v.exp_cnt = c; v.exp_dout = dout; v.exp_ovf = ov; v.exp_udf = ud;
    return v;
  endfunction

  // Reference model: FIFO behaviour stated as queue operations.
  task automatic model_step(input logic p, po, ec, rn, input logic [DW-1:0] d);
    int sz;
    if (!rn) begin
      exp_q.delete();
      return;
    end
    if (ec) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    sz = exp_q.size();
    if (p && po) begin
      if (sz == 0) m_udf = 1'b1;
      else void'(exp_q.pop_front());
      exp_q.push_back(d);
    end else if (p) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else exp_q.push_back(d);
    end else if (po) begin
      if (sz == 0) m_udf = 1'b1;
      else void'(exp_q.pop_front());
    end
  endtask

  task automatic chk_model(input string tag);
    int            sz;
    logic [DW-1:0] head;
    sz   = exp_q.size();
    head = '0;
    if (sz != 0) head = exp_q[0];
    chk({tag, ".cnt"},   DW'(cnt), DW'(sz));
    chk({tag, ".dout"},  data_out, head);
    chk({tag, ".full"},  DW'(full), DW'(sz == DEPTH));
    chk({tag, ".empty"}, DW'(empty), DW'(sz == 0));
    chk({tag, ".afull"}, DW'(almost_full), DW'(sz >= 6));
    chk({tag, ".aempty"},DW'(almost_empty), DW'(sz <= 2));
    chk({tag, ".ovf"},   DW'(overflow), DW'(m_ovf));
    chk({tag, ".udf"},   DW'(underflow), DW'(m_udf));
  endtask

  // Driver: inputs change on the falling edge, outputs are sampled 1ns after the rising edge.
  task automatic step(input string tag, input logic p, po, ec, rn, input logic [DW-1:0] d);
    @(negedge clk);
    push = p; pop = po; err_clr = ec; FIFO_reset_n = rn; data_in = d;
    @(posedge clk);
    model_step(p, po, ec, rn, d);
    #1;
    chk_model(tag);
  endtask

  initial begin
    logic [DW-1:0] heads [9];
    logic [DW-1:0] r;

    FIFO_clr_n = 1'b0; FIFO_reset_n = 1'b1; push = 1'b0; pop = 1'b0;
    err_clr = 1'b0; data_in = '0;
`ifdef FIFO_PARITY_EN
    par_inj = 1'b0;
`endif
    m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    chk("rst.cnt", DW'(cnt), 0);
    chk("rst.empty", DW'(empty), 1);
    chk("rst.aempty", DW'(almost_empty), 1);
    chk("rst.dout", data_out, 0);
    chk("rst.flags", DW'({overflow, underflow, full, almost_full}), 0);
    @(negedge clk);
    FIFO_clr_n = 1'b1;

    // Directed table: fill, overflow, push+pop on full, drain, underflow, err_clr
    for (int k = 1; k <= 8; k++)
      vtab.push_back(mk(1, 0, 0, 1, DW'(k * 32'h11), k, 32'h11, 0, 0));
    vtab.push_back(mk(1, 0, 0, 1, 32'hDEAD, 8, 32'h11, 1, 0));
    vtab.push_back(mk(1, 1, 0, 1, 32'hDEAD, 8, 32'h22, 1, 0));
    heads = '{32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'hDEAD, 32'h0};
    for (int i = 1; i <= 8; i++)
      vtab.push_back(mk(0, 1, 0, 1, '0, 8 - i, heads[i], 1, 0));
    vtab.push_back(mk(0, 1, 0, 1, '0, 0, '0, 1, 1));
    vtab.push_back(mk(0, 0, 1, 1, '0, 0, '0, 0, 0));
    vtab.push_back(mk(1, 1, 0, 1, 32'h5A, 1, 32'h5A, 0, 1));
    vtab.push_back(mk(0, 0, 1, 1, '0, 1, 32'h5A, 0, 0));
    foreach (vtab[i]) begin
      step("tab", vtab[i].p, vtab[i].po, vtab[i].ec, vtab[i].rn, vtab[i].din);
      chk($sformatf("tab%0d.cnt", i),  DW'(cnt), DW'(vtab[i].exp_cnt));
      chk($sformatf("tab%0d.dout", i), data_out, vtab[i].exp_dout);
      chk($sformatf("tab%0d.ovf", i),  DW'(overflow), DW'(vtab[i].exp_ovf));
      chk($sformatf("tab%0d.udf", i),  DW'(underflow), DW'(vtab[i].exp_udf));
    end

    // Steady occupancy of 3 with pointer wrap
    step("wrap.fill", 1, 0, 0, 1, 32'hA1);
    step("wrap.fill", 1, 0, 0, 1, 32'hA2);
    for (int i = 0; i < 20; i++) begin
      step("wrap", 1, 1, 0, 1, $urandom);
      chk("wrap.cnt3", DW'(cnt), 3);
      chk("wrap.flags", DW'({almost_full, almost_empty}), 0);
    end
    for (int i = 0; i < 3; i++) step("wrap.drain", 0, 1, 0, 1, '0);

    // Synchronous flush keeps error flags
    for (int i = 0; i < 9; i++) step("flush.fill", 1, 0, 0, 1, DW'(32'hB0 + i));
    for (int i = 0; i < 3; i++) step("flush.pop", 0, 1, 0, 1, '0);
    chk("flush.pre_cnt", DW'(cnt), 5);
    step("flush", 1, 1, 1, 0, 32'hFF);
    chk("flush.cnt", DW'(cnt), 0);
    chk("flush.ovf_kept", DW'(overflow), 1);
    step("flush.idle", 0, 0, 0, 1, '0);

    // Asynchronous clear mid-push
    for (int i = 0; i < 3; i++) step("aclr.fill", 1, 0, 0, 1, DW'(32'hC0 + i));
    @(negedge clk);
    push = 1'b1; pop = 1'b0; data_in = 32'hCAFE;
    #2 FIFO_clr_n = 1'b0;
    #1;
    exp_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    chk_model("aclr.now");
    @(posedge clk);
    #1;
    chk_model("aclr.edge");
    @(negedge clk);
    push = 1'b0; FIFO_clr_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      step("rnd", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) != 0), r);
    end

`ifdef FIFO_PARITY_EN
    step("par.clr", 0, 0, 1, 0, '0);
    step("par.clr", 0, 0, 1, 1, '0);
    for (int i = 0; i < 8; i++) step("par.drain", 0, 1, 1, 1, '0);
    step("par.clr", 0, 0, 1, 1, '0);
    chk("par.init", DW'(par_err), 0);
    par_inj = 1'b1;
    step("par.push1", 1, 0, 0, 1, 32'h1);
    par_inj = 1'b0;
    chk("par.before_pop", DW'(par_err), 0);
    step("par.pop1", 0, 1, 0, 1, '0);
    chk("par.set", DW'(par_err), 1);
    step("par.push3", 1, 0, 0, 1, 32'h3);
    step("par.pop3", 0, 1, 0, 1, '0);
    chk("par.sticky", DW'(par_err), 1);
    step("par.errclr", 0, 0, 1, 1, '0);
    chk("par.cleared", DW'(par_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
